mcs4_cycle_ctrl: RTL and testbench

Clock-phase generator and instruction-cycle sequencer for the i4004 core on an FPGA. From sysclk it generates the non-overlapping clk1_pad/clk2_pad pair and tracks the 8 subcycles A1 A2 A3 M1 M2 X1 X2 X3, realigning to the CPU's sync_pad. It provides run/halt/single-step control at instruction-cycle boundaries. It also arbitrates the shared 4-bit data bus between the CPU (data_dir) and external ROM.

---
 rtl/mcs4_cycle_ctrl_if.sv | 28 ++
 rtl/mcs4_cycle_ctrl.sv | 123 ++++++++++++
 tb/tb_mcs4_cycle_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mcs4_cycle_ctrl_if.sv
// Bundle of control, SYNC and data-bus arbitration signals between the cycle controller
// and the CPU/ROM side of the i4004 system.
interface mcs4_cycle_ctrl_if;
    logic       run;
    logic       step;
    logic       sync_pad;
    logic       data_dir;
    logic       clk1_pad;
    logic       clk2_pad;
    logic [2:0] subcycle;
    logic       cycle_start;
    logic       halted;
    logic       rom_drive;
    logic       sync_err;
    logic       bus_conflict;

    modport master (
        input  run, step, sync_pad, data_dir,
        output clk1_pad, clk2_pad, subcycle, cycle_start, halted, rom_drive, sync_err,
               bus_conflict
    );

    modport slave (
        output run, step, sync_pad, data_dir,
        input  clk1_pad, clk2_pad, subcycle, cycle_start, halted, rom_drive, sync_err,
               bus_conflict
    );
endinterface

// File: rtl/mcs4_cycle_ctrl.sv
// i4004 two-phase clock generator and A1..X3 subcycle sequencer with run/halt/step control,
// SYNC realignment and ROM data-bus ownership.
module mcs4_cycle_ctrl #(
    parameter int unsigned PHASE_TICKS = 4,
    parameter int unsigned GAP_TICKS   = 1
) (
    input logic               sysclk,
    input logic               poc,
    mcs4_cycle_ctrl_if.master bus
);
    localparam int unsigned T  = 2 * PHASE_TICKS + 2 * GAP_TICKS;
    localparam int unsigned TW = $clog2(T);

    localparam logic [TW-1:0] TickLast  = TW'(T - 1);
    localparam logic [TW-1:0] Clk1End   = TW'(PHASE_TICKS);
    localparam logic [TW-1:0] Clk2Start = TW'(PHASE_TICKS + GAP_TICKS);
    localparam logic [TW-1:0] Clk2End   = TW'(2 * PHASE_TICKS + GAP_TICKS);
    localparam logic [TW-1:0] SyncTick  = TW'(2 * PHASE_TICKS + GAP_TICKS - 1);

    typedef enum logic [1:0] {StHalt, StRun, StStep} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    sub_q, sub_d;
    logic          force_q, force_d;
    logic          clk1_q, clk1_d;
    logic          clk2_q, clk2_d;
    logic          cs_q, cs_d;
    logic          halted_q, halted_d;
    logic          rom_q, rom_d;
    logic          sync_err_q, sync_err_d;
    logic          conflict_q, conflict_d;
    logic          running_d;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        sub_d      = sub_q;
        force_d    = force_q;
        sync_err_d = sync_err_q;
        conflict_d = conflict_q | (rom_q & bus.data_dir);
        cs_d       = 1'b0;

        case (state_q)
            StHalt: begin
                if (bus.run) begin
                    state_d = StRun;
                end else if (bus.step) begin
                    state_d = StStep;
                end
            end
            default: begin
                // SYNC is judged once per subcycle, at the last clk2-high tick.
                if (tick_q == SyncTick) begin
                    if (bus.sync_pad && (sub_q != 3'd7)) begin
                        sync_err_d = 1'b1;
                        force_d    = 1'b1;
                    end else if (!bus.sync_pad && (sub_q == 3'd7)) begin
                        sync_err_d = 1'b1;
                    end
                end
                if (tick_q == TickLast) begin
                    tick_d  = '0;
                    force_d = 1'b0;
                    if ((sub_q == 3'd7) || force_q) begin
                        // Instruction-cycle boundary: the only point where run/step take effect.
                        sub_d   = 3'd0;
                        cs_d    = 1'b1;
                        state_d = bus.run ? StRun : StHalt;
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
        endcase

        // Outputs are registered from next-state so they line up with tick_q/sub_q.
        running_d = (state_d != StHalt);
        halted_d  = ~running_d;
        clk1_d    = running_d && (tick_d < Clk1End);
        clk2_d    = running_d && (tick_d >= Clk2Start) && (tick_d < Clk2End);
        rom_d     = running_d && ((sub_d == 3'd3) || (sub_d == 3'd4)) && (tick_d < Clk2End);
    end

    always_ff @(posedge sysclk) begin
        if (poc) begin
            state_q    <= StHalt;
            tick_q     <= '0;
            sub_q      <= 3'd0;
            force_q    <= 1'b0;
            clk1_q     <= 1'b0;
            clk2_q     <= 1'b0;
            cs_q       <= 1'b0;
            halted_q   <= 1'b1;
            rom_q      <= 1'b0;
            sync_err_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            sub_q      <= sub_d;
            force_q    <= force_d;
            clk1_q     <= clk1_d;
            clk2_q     <= clk2_d;
            cs_q       <= cs_d;
            halted_q   <= halted_d;
            rom_q      <= rom_d;
            sync_err_q <= sync_err_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.clk1_pad     = clk1_q;
    assign bus.clk2_pad     = clk2_q;
    assign bus.subcycle     = sub_q;
    assign bus.cycle_start  = cs_q;
    assign bus.halted       = halted_q;
    assign bus.rom_drive    = rom_q;
    assign bus.sync_err     = sync_err_q;
    assign bus.bus_conflict = conflict_q;
endmodule

// File: tb/tb_mcs4_cycle_ctrl.sv
// Bench for mcs4_cycle_ctrl: directed scenarios plus random run/step/SYNC/bus traffic compared
// cycle by cycle against a position-in-instruction-cycle reference model.
module tb_mcs4_cycle_ctrl;
    localparam int unsigned P = 4;
    localparam int unsigned G = 1;
    localparam int unsigned T = 2 * P + 2 * G;

    localparam int MHalt = 0;
    localparam int MRun  = 1;
    localparam int MStep = 2;

    logic sysclk = 1'b0;
    logic poc    = 1'b1;
    always #5 sysclk = ~sysclk;

    mcs4_cycle_ctrl_if bus ();

    mcs4_cycle_ctrl #(
        .PHASE_TICKS(P),
        .GAP_TICKS  (G)
    ) dut (
        .sysclk(sysclk),
        .poc   (poc),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position 0..8T-1 inside the instruction cycle plus a mode.
    int          m_mode  = MHalt;
    int unsigned m_pos   = 0;
    bit          m_force = 1'b0;
    bit          m_serr  = 1'b0;
    bit          m_conf  = 1'b0;
    bit          m_cs    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned m_sub();
        return m_pos / T;
    endfunction

    function automatic int unsigned m_tick();
        return m_pos % T;
    endfunction

    // {clk1, clk2, subcycle[2:0], cycle_start, halted, rom_drive, sync_err, bus_conflict}
    function automatic logic [9:0] exp_outs();
        int unsigned tk;
        int unsigned sb;
        logic        r;
        r  = (m_mode != MHalt);
        tk = m_tick();
        sb = m_sub();
        return {r && (tk < P), r && (tk >= P + G) && (tk < 2 * P + G), 3'(sb), m_cs, !r,
                r && ((sb == 3) || (sb == 4)) && (tk < 2 * P + G), m_serr, m_conf};
    endfunction

    function automatic logic [9:0] dut_outs();
        return {bus.clk1_pad, bus.clk2_pad, bus.subcycle, bus.cycle_start, bus.halted,
                bus.rom_drive, bus.sync_err, bus.bus_conflict};
    endfunction

    task automatic model_step(input bit p, input bit r, input bit s, input bit sy, input bit d);
        logic [9:0] prev;
        if (p) begin
            m_mode = MHalt; m_pos = 0; m_force = 0; m_serr = 0; m_conf = 0; m_cs = 0;
            return;
        end
        prev = exp_outs();
        if (prev[2] && d) m_conf = 1'b1;
        m_cs = 1'b0;
        if (m_mode == MHalt) begin
            if (r) m_mode = MRun;
            else if (s) m_mode = MStep;
        end else begin
            if (m_tick() == 2 * P + G - 1) begin
                if (sy && m_sub() != 7) begin
                    m_serr = 1'b1; m_force = 1'b1;
                end else if (!sy && m_sub() == 7) begin
                    m_serr = 1'b1;
                end
            end
            if (m_tick() == T - 1 && (m_sub() == 7 || m_force)) begin
                m_pos = 0; m_force = 0; m_cs = 1'b1;
                m_mode = r ? MRun : MHalt;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic cyc(input bit p, input bit r, input bit s, input bit sy, input bit d);
        poc = p; bus.run = r; bus.step = s; bus.sync_pad = sy; bus.data_dir = d;
        @(posedge sysclk);
        model_step(p, r, s, sy, d);
        @(negedge sysclk);
        check_eq("outs", 32'(dut_outs()), 32'(exp_outs()));
    endtask

    function automatic bit good_sync();
        return (m_mode != MHalt) && (m_sub() == 7);
    endfunction

    task automatic go(input int n, input bit r, input bit d);
        for (int i = 0; i < n; i++) cyc(1'b0, r, 1'b0, good_sync(), d);
    endtask

    task automatic reset_run();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        go(1, 1'b1, 1'b0);
    endtask

    // Advance while running until the first tick of subcycle s.
    task automatic goto_sub(input int unsigned s);
        for (int i = 0; i < 10 * T && !(m_sub() == s && m_tick() == 0); i++) go(1, 1'b1, 1'b0);
        check_eq("reach_sub", 32'(bus.subcycle), 32'(s));
    endtask

    logic [9:0] rst_vec;
    int         n_clk1, n_clk2, n_cs;
    logic       p1, p2;
    bit         r_run;

    initial begin
        bus.run = 0; bus.step = 0; bus.sync_pad = 0; bus.data_dir = 0;
        rst_vec = {1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state, then free run for a few instruction cycles.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_state", 32'(dut_outs()), 32'(rst_vec));
        go(1, 1'b1, 1'b0);
        check_eq("first_clk1", 32'(bus.clk1_pad), 32'd1);
        go(3 * 8 * T, 1'b1, 1'b0);

        // Drop run mid-cycle: must finish through X3 before halting.
        goto_sub(3);
        for (int i = 0; i < 10 * T && m_mode != MHalt; i++) go(1, 1'b0, 1'b0);
        check_eq("halt_boundary", 32'({bus.halted, bus.subcycle, bus.cycle_start}), 32'(5'b1_000_1));
        go(5, 1'b0, 1'b0);

        // Single step, with a second (ignored) step while running.
        n_clk1 = 0; n_clk2 = 0; n_cs = 0; p1 = 0; p2 = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 * T; i++) begin
            if (bus.clk1_pad && !p1) n_clk1++;
            if (bus.clk2_pad && !p2) n_clk2++;
            if (bus.cycle_start) n_cs++;
            p1 = bus.clk1_pad; p2 = bus.clk2_pad;
            if (bus.halted) break;
            cyc(1'b0, 1'b0, (i == 30), good_sync(), 1'b0);
        end
        check_eq("step_clk1", 32'(n_clk1), 32'd8);
        check_eq("step_clk2", 32'(n_clk2), 32'd8);
        check_eq("step_cs", 32'(n_cs), 32'd1);
        check_eq("step_halted", 32'(bus.halted), 32'd1);
        go(10, 1'b0, 1'b0);

        // Early SYNC in subcycle 5 forces the next subcycle to A1.
        reset_run();
        goto_sub(5);
        for (int i = 0; i < T; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("early_sync_err", 32'(bus.sync_err), 32'd1);
        check_eq("early_sync_a1", 32'({bus.subcycle, bus.cycle_start}), 32'(4'b000_1));
        go(2 * T, 1'b1, 1'b0);

        // Missing SYNC at X3 flags but the sequence carries on.
        reset_run();
        goto_sub(7);
        for (int i = 0; i < T; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("missing_sync_err", 32'(bus.sync_err), 32'd1);
        check_eq("missing_sync_a1", 32'(bus.subcycle), 32'd0);
        go(T, 1'b1, 1'b0);

        // Bus conflict while ROM owns the bus is sticky; none outside M1/M2.
        reset_run();
        goto_sub(3);
        go(T, 1'b1, 1'b1);
        check_eq("conflict_set", 32'(bus.bus_conflict), 32'd1);
        go(8 * T, 1'b1, 1'b0);
        check_eq("conflict_sticky", 32'(bus.bus_conflict), 32'd1);
        reset_run();
        goto_sub(6);
        go(T, 1'b1, 1'b1);
        check_eq("conflict_clear", 32'(bus.bus_conflict), 32'd0);

        // Reset while clk2 is high in subcycle 4.
        goto_sub(4);
        go(P + G + 1, 1'b1, 1'b0);
        check_eq("clk2_high_pre", 32'(bus.clk2_pad), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("poc_mid", 32'(dut_outs()), 32'(rst_vec));

        // Random traffic.
        r_run = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(149) == 0) r_run = ~r_run;
            cyc($urandom_range(599) == 0, r_run, $urandom_range(39) == 0,
                good_sync() ^ ($urandom_range(299) == 0), $urandom_range(199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
